// File: rtl/sbio_queued_transmitter.sv
// Queued sbio line transmitter: FIFO of variable-length messages sent as
// idle-ones / one all-zero start cycle / LSB-first payload, with a programmable idle gap.
module sbio_queued_transmitter #(
    parameter int IO_BITS            = 2,
    parameter int MAX_PAYLOAD_CYCLES = 10,
    parameter int FIFO_DEPTH         = 4,
    parameter int GAP_BITS           = 4,
    parameter int PB                 = IO_BITS * MAX_PAYLOAD_CYCLES,
    parameter int LEN_BITS           = $clog2(MAX_PAYLOAD_CYCLES + 1),
    parameter int CNT_BITS           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PB-1:0]       in_payload,
    input  logic [LEN_BITS-1:0] in_len,
    input  logic [GAP_BITS-1:0] min_gap,
    output logic [IO_BITS-1:0]  tx_pins,
    output logic                busy,
    output logic [CNT_BITS-1:0] fifo_count,
    output logic                msg_sent
);

    localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_BITS-1:0] DEPTH_C   = CNT_BITS'(FIFO_DEPTH);
    localparam logic [LEN_BITS-1:0] MAX_LEN_C = LEN_BITS'(MAX_PAYLOAD_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [PB-1:0]         sreg_q, sreg_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic [GAP_BITS-1:0]   gap_q, gap_d;
    logic [PB-1:0]         pay_mem_q [FIFO_DEPTH];
    logic [PB-1:0]         pay_mem_d [FIFO_DEPTH];
    logic [LEN_BITS-1:0]   len_mem_q [FIFO_DEPTH];
    logic [LEN_BITS-1:0]   len_mem_d [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]   count_q, count_d;

    logic                  push_s, pop_s, fifo_empty_s, ready_s;
    logic [PB-1:0]         head_pay_s;
    logic [LEN_BITS-1:0]   head_len_s, len_clamped_s;

    assign ready_s      = (count_q < DEPTH_C);
    assign fifo_empty_s = (count_q == CNT_BITS'(0));
    assign head_pay_s   = pay_mem_q[rd_ptr_q];
    assign head_len_s   = len_mem_q[rd_ptr_q];
    assign push_s       = in_valid && ready_s;

    // FIFO bookkeeping: store clamped length on push, advance pointers, track count
    always_comb begin
        pay_mem_d     = pay_mem_q;
        len_mem_d     = len_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        len_clamped_s = (in_len > MAX_LEN_C) ? MAX_LEN_C : in_len;
        if (push_s) begin
            pay_mem_d[wr_ptr_q] = in_payload;
            len_mem_d[wr_ptr_q] = len_clamped_s;
            wr_ptr_d            = wr_ptr_q + PTR_BITS'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_BITS'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_BITS'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Next-state logic; a zero-length head is popped and dropped only from IDLE
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        len_d   = len_q;
        gap_d   = gap_q;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (head_len_s != LEN_BITS'(0)) begin
                        state_d = S_START;
                        sreg_d  = head_pay_s;
                        len_d   = head_len_s;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                sreg_d = sreg_q >> IO_BITS;
                len_d  = len_q - LEN_BITS'(1);
                if (len_q == LEN_BITS'(1)) begin
                    if (min_gap != GAP_BITS'(0)) begin
                        state_d = S_GAP;
                        gap_d   = min_gap;
                    end else if (!fifo_empty_s && (head_len_s != LEN_BITS'(0))) begin
                        pop_s   = 1'b1;
                        state_d = S_START;
                        sreg_d  = head_pay_s;
                        len_d   = head_len_s;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_GAP: begin
                if (gap_q <= GAP_BITS'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_BITS'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and FIFO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sreg_q   <= '0;
            len_q    <= LEN_BITS'(0);
            gap_q    <= GAP_BITS'(0);
            wr_ptr_q <= PTR_BITS'(0);
            rd_ptr_q <= PTR_BITS'(0);
            count_q  <= CNT_BITS'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pay_mem_q[i] <= '0;
                len_mem_q[i] <= LEN_BITS'(0);
            end
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pay_mem_q <= pay_mem_d;
            len_mem_q <= len_mem_d;
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        in_ready   = ready_s;
        fifo_count = count_q;
        busy       = !fifo_empty_s || (state_q != S_IDLE);
        msg_sent   = (state_q == S_DATA) && (len_q == LEN_BITS'(1));
        case (state_q)
            S_START: tx_pins = {IO_BITS{1'b0}};
            S_DATA:  tx_pins = sreg_q[IO_BITS-1:0];
            default: tx_pins = {IO_BITS{1'b1}};
        endcase
    end

endmodule

// File: doc/sbio_queued_transmitter.md
Name: sbio_queued_transmitter

Overview:
- Successor to the fixed-length sbio transmitter. Same line format: idle all-ones, one start cycle with all pins low, then payload shifted out LSB-first, IO_BITS per cycle.
- Adds an input FIFO of pending messages.
- Adds a per-message payload length, 1..MAX_PAYLOAD_CYCLES.
- Adds a runtime-programmable minimum idle gap between messages.
- Sits between the request-generation logic and the tx pins toward the PIO RAM emulator.

Parameters:
- IO_BITS, 2, pins driven per cycle.
- MAX_PAYLOAD_CYCLES, 10, longest payload in cycles; payload width PB = IO_BITS*MAX_PAYLOAD_CYCLES.
- FIFO_DEPTH, 4, queued messages; power of two, at least 2.
- GAP_BITS, 4, width of min_gap.
- Derived: LEN_BITS = $clog2(MAX_PAYLOAD_CYCLES+1); CNT_BITS = $clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  message offered.
- in_ready  out  1  FIFO can accept.
- in_payload  in  PB  payload; bits [IO_BITS-1:0] are sent first.
- in_len  in  LEN_BITS  payload cycles.
- min_gap  in  GAP_BITS  idle cycles forced after each message.
- tx_pins  out  IO_BITS  line output.
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- fifo_count  out  CNT_BITS  entries queued.
- msg_sent  out  1  one-cycle pulse during the last payload cycle.

Behaviour:
- One clock; synchronous active-high reset.
- On reset:
  - FSM goes to IDLE, FIFO is emptied.
  - tx_pins all ones, in_ready=1, busy=0, fifo_count=0, msg_sent=0.
  - All of these hold in the cycle after reset is sampled.
  - Reset mid-message truncates the message; the line returns to idle with no further start bit. Queued entries are lost.
- Push:
  - A push occurs when in_valid && in_ready at a rising edge.
  - in_ready = (fifo_count < FIFO_DEPTH), decoded from registered count only.
  - When full, no push is accepted even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
- Length rules, applied on push:
  - in_len > MAX_PAYLOAD_CYCLES is clamped to MAX_PAYLOAD_CYCLES.
  - in_len == 0 is stored; the entry is popped and discarded in IDLE, taking one cycle, with no line activity and no msg_sent.
- tx_pins is decoded only from registered FSM state and the shift register. There is no combinational path from inputs.
- FSM IDLE:
  - tx_pins all ones.
  - If the FIFO is non-empty, pop the head, load the shift register and the length counter, and go to START.
- FSM START:
  - tx_pins all zeros for exactly one cycle, then DATA.
- FSM DATA:
  - tx_pins = sreg[IO_BITS-1:0]; sreg shifts right by IO_BITS each cycle.
  - Lasts exactly len cycles. msg_sent is high on the last one.
  - At the end of the last DATA cycle, min_gap is sampled:
    - If min_gap == 0 and the FIFO is non-empty, pop and go directly to START. This is back-to-back with no idle cycle.
    - If min_gap == 0 and the FIFO is empty, go to IDLE.
    - Otherwise go to GAP with a counter set to min_gap.
- FSM GAP:
  - tx_pins all ones for exactly min_gap cycles (the sampled value), then IDLE.
  - A message waiting in IDLE starts on the next cycle.
- Latency: a push at the edge ending cycle N, with the FSM IDLE and the FIFO empty, gives a start bit on tx_pins in cycle N+2. The first payload cycle is N+3.
- Changes to min_gap during DATA or GAP affect only later messages.
- Payload bits above len*IO_BITS are ignored.

Test Plan:
- Single message, defaults, min_gap=0: push in_payload=20'hABCDE, in_len=10 in cycle N.
  - tx_pins=11 in N and N+1; 00 in N+2.
  - Then 10,11,01,11,00,11,11,10,10,10 in N+3..N+12; msg_sent=1 in N+12 only; 11 in N+13; busy=0 in N+13.
- Back-to-back: push two len=3 messages in N and N+1 with min_gap=0.
  - The second start bit (00) appears in the cycle right after the first message's last payload cycle, with no 11 cycle between.
- Gap: same as the back-to-back case with min_gap=3.
  - Exactly three 11 cycles, then IDLE, then the start bit: four 11 cycles total between messages.
  - Changing min_gap to 0 during GAP does not shorten the gap.
- Full FIFO: hold in_valid while the first message transmits.
  - in_ready drops after 5 accepts (1 popped plus 4 queued); fifo_count=4.
  - It rises again the cycle after the next pop; all messages appear in order.
- Length corner cases:
  - in_len=0 produces no line activity and no msg_sent; the FIFO drains.
  - in_len=15 transmits exactly 10 payload cycles.
  - in_len=1 gives start plus one payload cycle.
- Reset mid-DATA with 2 entries queued: cycle after reset shows tx_pins=11, fifo_count=0, busy=0, in_ready=1. No start bit follows.
